// File: rtl/robo_ambiente.sv
// robo_ambiente: world model answering the robot controller's sensor/command interface.
// Holds the pipe map, the robot pose, the debris-removal counter and the step count.
module robo_ambiente #(
    parameter int LINHAS      = 10,
    parameter int COLUNAS     = 20,
    parameter int VIDA_LEVE   = 3,
    parameter int VIDA_MEDIO  = 6,
    parameter int VIDA_PESADO = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        map_we,
    input  logic [3:0]  map_linha,
    input  logic [4:0]  map_coluna,
    input  logic [3:0]  map_dado,
    input  logic [3:0]  init_linha,
    input  logic [4:0]  init_coluna,
    input  logic [1:0]  init_orient,
    input  logic        start,
    input  logic        avancar,
    input  logic        girar,
    input  logic        recolher_entulho,
    output logic        head,
    output logic        left,
    output logic        under,
    output logic        barrier,
    output logic [3:0]  linha,
    output logic [4:0]  coluna,
    output logic [1:0]  orientacao,
    output logic [3:0]  entulho_restante,
    output logic [15:0] passos,
    output logic        anomalia,
    output logic        ativo
);
    typedef enum logic [1:0] {CARGA, ATIVO, ANOMALIA} estado_t;
    localparam logic [1:0] N = 2'b00, S = 2'b01, L = 2'b10, O = 2'b11;
    localparam logic [3:0] LMAX = 4'(LINHAS - 1);
    localparam logic [4:0] CMAX = 5'(COLUNAS - 1);

    estado_t     estado_q, estado_d;
    logic [3:0]  linha_q, linha_d;
    logic [4:0]  coluna_q, coluna_d;
    logic [1:0]  orient_q, orient_d;
    logic [3:0]  cont_q, cont_d, cont_eff, vida;
    logic [15:0] passos_q, passos_d, passos_inc;
    logic [3:0]  map_q [LINHAS][COLUNAS];
    logic [3:0]  map_d [LINHAS][COLUNAS];
    logic [3:0]  al, ll, ahead_val, left_val, init_val;
    logic [4:0]  ac, lc;
    logic        ahead_in, left_in, init_in, em_ativo;

    always_comb begin
        al       = linha_q;
        ac       = coluna_q;
        ll       = linha_q;
        lc       = coluna_q;
        ahead_in = 1'b0;
        left_in  = 1'b0;
        unique case (orient_q)
            N: begin
                ahead_in = linha_q != 4'd0;
                al       = linha_q - 4'd1;
                left_in  = coluna_q != 5'd0;
                lc       = coluna_q - 5'd1;
            end
            S: begin
                ahead_in = linha_q < LMAX;
                al       = linha_q + 4'd1;
                left_in  = coluna_q < CMAX;
                lc       = coluna_q + 5'd1;
            end
            L: begin
                ahead_in = coluna_q < CMAX;
                ac       = coluna_q + 5'd1;
                left_in  = linha_q != 4'd0;
                ll       = linha_q - 4'd1;
            end
            O: begin
                ahead_in = coluna_q != 5'd0;
                ac       = coluna_q - 5'd1;
                left_in  = linha_q < LMAX;
                ll       = linha_q + 4'd1;
            end
        endcase
    end

    assign ahead_val  = ahead_in ? map_q[al][ac] : 4'd0;
    assign left_val   = left_in ? map_q[ll][lc] : 4'd0;
    assign init_in    = (init_linha <= LMAX) && (init_coluna <= CMAX);
    assign init_val   = init_in ? map_q[init_linha][init_coluna] : 4'd1;
    assign em_ativo   = estado_q == ATIVO;
    assign head       = em_ativo && (!ahead_in || ahead_val == 4'd1);
    assign left       = em_ativo && (!left_in || left_val == 4'd1);
    assign barrier    = em_ativo && ahead_in && ahead_val >= 4'd3;
    assign under      = em_ativo && map_q[linha_q][coluna_q] == 4'd2;
    assign vida       = ahead_val == 4'd3 ? 4'(VIDA_LEVE) :
                        ahead_val == 4'd4 ? 4'(VIDA_MEDIO) : 4'(VIDA_PESADO);
    assign passos_inc = passos_q == 16'hFFFF ? passos_q : passos_q + 16'd1;

    always_comb begin
        estado_d = estado_q;
        linha_d  = linha_q;
        coluna_d = coluna_q;
        orient_d = orient_q;
        cont_d   = cont_q;
        passos_d = passos_q;
        map_d    = map_q;
        cont_eff = (barrier && cont_q == 4'd0) ? vida : cont_q;
        if (estado_q == CARGA) begin
            if (map_we && map_linha <= LMAX && map_coluna <= CMAX)
                map_d[map_linha][map_coluna] = map_dado;
            if (start) begin
                linha_d  = init_linha;
                coluna_d = init_coluna;
                orient_d = init_orient;
                estado_d = (init_in && init_val != 4'd1 && init_val < 4'd3) ? ATIVO : ANOMALIA;
            end
        end else if (em_ativo) begin
            cont_d = cont_eff;
            if (recolher_entulho && cont_eff != 4'd0) begin
                cont_d = cont_eff - 4'd1;
                if (cont_eff == 4'd1 && ahead_in)
                    map_d[al][ac] = 4'd0;
            end else if (avancar) begin
                if (ahead_in && (ahead_val == 4'd0 || ahead_val == 4'd2)) begin
                    linha_d  = al;
                    coluna_d = ac;
                    passos_d = passos_inc;
                end else begin
                    estado_d = ANOMALIA;
                end
            end else if (girar) begin
                // left turn: N -> O -> S -> L -> N
                orient_d = orient_q == N ? O : orient_q == O ? S : orient_q == S ? L : N;
                passos_d = passos_inc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= CARGA;
            linha_q  <= '0;
            coluna_q <= '0;
            orient_q <= N;
            cont_q   <= '0;
            passos_q <= '0;
            for (int i = 0; i < LINHAS; i++)
                for (int j = 0; j < COLUNAS; j++)
                    map_q[i][j] <= '0;
        end else begin
            estado_q <= estado_d;
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
            orient_q <= orient_d;
            cont_q   <= cont_d;
            passos_q <= passos_d;
            map_q    <= map_d;
        end
    end

    assign linha            = linha_q;
    assign coluna           = coluna_q;
    assign orientacao       = orient_q;
    assign entulho_restante = cont_q;
    assign passos           = passos_q;
    assign anomalia         = estado_q == ANOMALIA;
    assign ativo            = em_ativo;
endmodule

// File: doc/robo_ambiente.md
Name: robo_ambiente

Overview:
- Synthesizable world model: the responder side of the robot controller's sensor/command interface.
- Holds the 10x20 pipe map, robot position and orientation.
- Drives head/left/under/barrier from that state.
- Consumes avancar/girar/recolher_entulho each clock: moves, turns, and times debris removal.
- Flags anomalous states. Used for FPGA-in-the-loop runs of the robot controller, replacing the behavioural bench environment.

Parameters:
- LINHAS, 10, map rows
- COLUNAS, 20, map columns
- VIDA_LEVE, 3, removal cycles for cell value 3
- VIDA_MEDIO, 6, removal cycles for cell value 4
- VIDA_PESADO, 9, removal cycles for cell value 5

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state including map
- map_we  in  1  map cell write strobe (CARGA only)
- map_linha  in  4  write row
- map_coluna  in  5  write column
- map_dado  in  4  cell value: 0 free, 1 wall, 2 black, 3/4/5 debris light/medium/heavy
- init_linha  in  4  start row
- init_coluna  in  5  start column
- init_orient  in  2  start orientation: N=00, S=01, L=10, O=11
- start  in  1  one-cycle pulse, CARGA -> ATIVO
- avancar  in  1  move-forward command from controller
- girar  in  1  turn-left command from controller
- recolher_entulho  in  1  debris-removal command from controller
- head  out  1  wall or map edge directly ahead
- left  out  1  wall or map edge on robot's left
- under  out  1  current cell == 2
- barrier  out  1  cell ahead in-range and >=3
- linha  out  4  current row
- coluna  out  5  current column
- orientacao  out  2  current orientation
- entulho_restante  out  4  debris removal counter
- passos  out  16  executed moves plus turns, saturating at FFFF
- anomalia  out  1  high in ANOMALIA
- ativo  out  1  high in ATIVO

Behaviour:
- Reset (async, reset=0):
  - state CARGA; all map cells 0.
  - linha=0, coluna=0, orientacao=N; counter=0, passos=0.
  - All sensors 0; anomalia=0, ativo=0.
- Neighbour definitions (outside the map counts as edge):
  - Ahead cell: N (l-1,c), S (l+1,c), L (l,c+1), O (l,c-1).
  - Left cell: N (l,c-1), S (l,c+1), L (l-1,c), O (l+1,c).
- Sensors: combinational from registered state, valid only in ATIVO, forced 0 elsewhere.
  - head/left = 1 if the neighbour is outside the map or ==1.
  - barrier = 0 at edge, else (ahead >=3).
- CARGA:
  - map_we writes map[map_linha][map_coluna]; out-of-range address is ignored.
  - start latches init_*.
  - If the start cell is out of range, ==1 or >=3: go to ANOMALIA, else ATIVO.
  - Commands ignored.
- ATIVO, per rising edge, evaluated in this order:
  1. If barrier=1 and counter==0, counter loads VIDA for the ahead value.
  2. If recolher_entulho=1 and the effective counter >0: counter decrements. On reaching 0, the ahead cell is written 0. No move or turn.
  3. Else if avancar=1:
     - Target cell in range and value 0 or 2: position updates, passos+1.
     - Otherwise (outside the map, ==1 or >=3): go to ANOMALIA with position unchanged.
  4. Else if girar=1: orientation N->O->S->L->N, passos+1.
  5. recolher with counter 0 and no other command: no-op.
- Multiple commands in one cycle: step 2 beats avancar, avancar beats girar.
- Counter holds its value if the robot turns away from the debris. It is consumed by the next debris reached.
- map_we and start are ignored in ATIVO and ANOMALIA.
- ANOMALIA:
  - All state frozen; anomalia=1.
  - Exit only by reset.
- passos saturates at 16'hFFFF.

Test Plan:
- Start cell (2,3) holds 1 -> one edge after start: anomalia=1, ativo=0, sensors 0.
- Map all 0, start (0,0) N:
  - head=1, left=1.
  - girar -> orientacao=O, head=1, left=0, passos=1.
  - avancar -> anomalia=1, linha=0, coluna=0.
- Cell (4,5)=4, robot (5,5) N:
  - barrier=1.
  - Six recolher cycles -> entulho_restante goes 5,4,3,2,1,0; map(4,5)=0 after the sixth; barrier=0.
  - Then avancar -> linha=4.
- Same setup, one cycle with recolher+avancar+girar asserted -> only decrement; linha and orientacao unchanged.
- Cell (3,7)=2, robot (4,7) N, avancar -> linha=3, under=1, passos=1.
- Assert reset mid-removal with counter=4 -> immediately CARGA, counter=0, map(…)=0, outputs at reset values.
